// File: rtl/mul_share_arbiter.sv
// Round-robin share of one registered signed multiplier across NUM_REQ requesters; product appears one cycle after accept.
// A stalled response (rsp_valid & !rsp_ready) drops mul_ce and every req_ready, so the product and the pointer hold.
module mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          mul_ce,
    output logic [DATA_WIDTH-1:0]         mul_din0,
    output logic [DATA_WIDTH-1:0]         mul_din1,
    input  logic [DATA_WIDTH-1:0]         mul_dout,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready,
    output logic [31:0]                   issue_cnt
);

    logic                s_vld;
    logic [ID_WIDTH-1:0] s_id;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] gnt_id;
    logic [ID_WIDTH-1:0] cand;
    logic                gnt_any;
    logic                advance;
    logic [ID_WIDTH-1:0] ptr_nxt;

    function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    assign advance = !s_vld || rsp_ready;
    assign mul_ce  = advance;

    // Scan from the farthest candidate back to ptr so the closest valid index is written last and wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_idx(ptr, k);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && gnt_id == ID_WIDTH'(i)) begin
                req_ready[i] = advance;
                mul_din0     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                mul_din1     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_nxt = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_vld     <= 1'b0;
            s_id      <= '0;
            ptr       <= '0;
            issue_cnt <= '0;
        end else if (advance) begin
            s_vld <= gnt_any;
            s_id  <= gnt_id;
            if (gnt_any) begin
                ptr       <= ptr_nxt;
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end

    // The multiplier's own output register is the product stage; s_vld/s_id only track its owner.
    assign rsp_valid = s_vld;
    assign rsp_id    = s_id;
    assign rsp_data  = mul_dout;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and random-soak bench for mul_share_arbiter with a behavioural registered multiplier.
module tb_mul_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             mul_ce;
    logic [W-1:0]     mul_din0;
    logic [W-1:0]     mul_din1;
    logic [W-1:0]     mul_dout;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_ready;
    logic [31:0]      issue_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  p;
    } exp_t;

    exp_t        sbq[$];
    logic        exp_vld;
    int          exp_ptr;
    logic [31:0] acc_cnt;
    int          waits[N];
    int          max_wait;
    logic        last_acc;
    int          last_gid;
    logic [W-1:0] held;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .issue_cnt(issue_cnt)
    );

    function automatic logic [W-1:0] mref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] f;
        f = $signed(a) * $signed(b);
        return f[W-1:0];
    endfunction

    // External multiplier: ce-gated output register, not reset.
    always_ff @(posedge clk) begin
        if (mul_ce) mul_dout <= mref(mul_din0, mul_din1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic model_reset();
        exp_vld = 1'b0;
        exp_ptr = 0;
        acc_cnt = '0;
        sbq.delete();
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    // One clock: called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cyc();
        logic         adv;
        logic         any;
        int           gid;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        #1;
        adv = !exp_vld || rsp_ready;
        any = 1'b0;
        gid = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (exp_ptr + k) % N;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                gid = idx;
            end
        end
        exp_rdy = (adv && any) ? N'(1 << gid) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mul_ce", 64'(mul_ce), 64'(adv));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
        chk("issue_cnt", 64'(issue_cnt), 64'(acc_cnt));
        if (adv && any) begin
            chk("mul_din0", 64'(mul_din0), 64'(req_a[gid*W +: W]));
            chk("mul_din1", 64'(mul_din1), 64'(req_b[gid*W +: W]));
        end
        if (exp_vld) begin
            chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
            chk("rsp_data", 64'(rsp_data), 64'(sbq[0].p));
            if (rsp_ready) void'(sbq.pop_front());
        end
        last_acc = adv && any;
        last_gid = gid;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) waits[i] = 0;
            else if (last_acc) begin
                if (i == gid) waits[i] = 0;
                else begin
                    waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end
            end
        end
        if (last_acc) begin
            e.id = IW'(gid);
            e.p  = mref(req_a[gid*W +: W], req_b[gid*W +: W]);
            sbq.push_back(e);
            acc_cnt = acc_cnt + 32'd1;
            exp_ptr = (gid + 1) % N;
        end
        @(posedge clk);
        if (adv) exp_vld = any;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        max_wait  = 0;
        last_acc  = 1'b0;
        last_gid  = 0;
        held      = '0;
        model_reset();

        // Reset state
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("rst_mul_ce", 64'(mul_ce), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: single request 7 * -3
        req_valid = 4'b0001;
        set_req(0, 32'd7, 32'hFFFF_FFFD);
        cyc();
        chk("t1_accepted", 64'(last_acc), 64'd1);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'd0);
        chk("t1_rsp_data", 64'(rsp_data), 64'hFFFF_FFEB);
        chk("t1_issue_cnt", 64'(issue_cnt), 64'd1);
        req_valid = '0;
        cyc();

        // 2: all requesters continuously valid; pointer sits at 1 after test 1
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        for (int j = 0; j < 8; j++) begin
            cyc();
            chk("t2_gnt_order", 64'(last_gid), 64'((j + 1) % N));
            set_req(last_gid, $urandom, $urandom);
        end

        // 3: backpressure with req2 pending
        req_valid = 4'b0010;
        cyc();
        chk("t3_gnt1", 64'(last_gid), 64'd1);
        held      = rsp_data;
        req_valid = 4'b0100;
        set_req(2, 32'h0001_2345, 32'hFFFF_FF00);
        rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("t3_ce_low", 64'(mul_ce), 64'd0);
            chk("t3_rdy_low", 64'(req_ready), 64'd0);
            chk("t3_data_stable", 64'(rsp_data), 64'(held));
        end
        rsp_ready = 1'b1;
        cyc();
        chk("t3_req2_acc", 64'(last_acc), 64'd1);
        chk("t3_req2_gid", 64'(last_gid), 64'd2);
        chk("t3_rsp_id", 64'(rsp_id), 64'd2);
        chk("t3_rsp_data", 64'(rsp_data), 64'h0123_4500 ^ 64'h0123_4500 ^ 64'hFEDC_BB00);

        // 4: wrap from req3 to req0, extreme operands
        req_valid = 4'b1000;
        set_req(3, 32'h8000_0000, 32'h8000_0000);
        cyc();
        chk("t4_gnt3", 64'(last_gid), 64'd3);
        chk("t4_min_sq", 64'(rsp_data), 64'd0);
        req_valid = 4'b0011;
        set_req(0, 32'h7FFF_FFFF, 32'd2);
        set_req(1, $urandom, $urandom);
        cyc();
        chk("t4_wrap_gnt0", 64'(last_gid), 64'd0);
        chk("t4_max_x2", 64'(rsp_data), 64'hFFFF_FFFE);
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        cyc();

        // 5: asynchronous reset with a product in flight
        req_valid = 4'b0001;
        set_req(0, 32'd5, 32'd9);
        cyc();
        req_valid = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("t5_rsp_id", 64'(rsp_id), 64'd0);
        model_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b0101;
        set_req(2, 32'd3, 32'd4);
        cyc();
        chk("t5_gnt0_first", 64'(last_gid), 64'd0);
        req_valid = 4'b0100;
        cyc();
        chk("t5_gnt2_next", 64'(last_gid), 64'd2);
        req_valid = '0;
        cyc();

        // 6: random soak; requesters hold valid and operands until accepted
        max_wait = 0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    set_req(i, $urandom, $urandom);
                end
            end
            cyc();
            if (last_acc) req_valid[last_gid] = 1'b0;
        end
        chk("t6_fair_max_wait_ok", 64'(max_wait < N), 64'd1);
        chk("t6_issue_cnt", 64'(issue_cnt), 64'(acc_cnt));
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
